arp_scheduler: RTL and testbench
================================

// Module: arp_scheduler
// PURPOSE
//  Arpeggiator/step scheduler in front of frequency_divider in synth_top.
//  Takes the bitmask of held keypad keys and plays them one at a time at a fixed tempo.
//  Drives the 4-bit keycode consumed by frequency_divider, plus a gate for downstream muting.
//  Replaces the direct keypad_encoder keycode path when arpeggio mode is selected.
// PARAMETERS
//  NUM_KEYS     13         held-key mask width; 1..15; key i -> keycode i+1
//  STEP_CYCLES  1_500_000  clk cycles per step (125 ms @ 12 MHz); >= 2
//  GATE_CYCLES  1_125_000  cycles gate is high within a step; 1 <= GATE_CYCLES < STEP_CYCLES
//  CNT_W        21         step counter width; 2**CNT_W > STEP_CYCLES
// PORTS
//  clk          in   1         system clock (12 MHz)
//  n_rst        in   1         reset; synchronous, active-low
//  en           in   1         global enable; low = freeze counters/state, gate forced 0
//  keys_held    in   NUM_KEYS  level mask of currently held keys; bit i = key i
//  dir          in   2         00 up, 01 down, 1x up (see CONFIGURATION)
//  keycode      out  4         note to frequency_divider; 0 = silence
//  gate         out  1         note sounding
//  step_pulse   out  1         1-cycle strobe on every new note issued
// BEHAVIOUR
//  - One clock; synchronous active-low reset. All outputs are registered.
//  - Reset state: IDLE, keycode=0, gate=0, step_pulse=0, step counter=0, cur_idx=0.
//  - FSM states: IDLE, NOTE (gate high), GAP (gate low, waiting for step end).
//  - IDLE -> NOTE when en=1 and keys_held!=0.
//    - Start index: lowest set bit for up; highest set bit for down.
//    - keycode=idx+1, gate=1 and step_pulse=1 on the cycle after detection.
//    - Step counter restarts at 0.
//  - Step counter counts 0..STEP_CYCLES-1 while en=1, then wraps to 0.
//  - NOTE -> GAP when counter reaches GATE_CYCLES-1. gate falls on the following cycle.
//    keycode holds its value through GAP.
//  - Step end (counter == STEP_CYCLES-1), from NOTE or GAP, samples keys_held that cycle:
//    - Mask nonzero: next idx = nearest set bit strictly after cur_idx in the current
//      direction, wrapping modulo NUM_KEYS.
//    - Single held key: that key repeats.
//    - Enter NOTE with step_pulse=1.
//    - Mask zero: go to IDLE, keycode=0, gate=0.
//  - Key release mid-step:
//    - If bit cur_idx clears while in NOTE: gate drops next cycle, state goes to GAP,
//      timing is unchanged.
//    - If mask becomes 0 in any state: IDLE next cycle (keycode=0, gate=0).
//  - Press and step end in the same cycle: the new press is included in the next-key search.
//  - dir change takes effect at the next step end; never retimes the current step.
//  - en=0: counter, FSM and keycode hold; gate=0, step_pulse=0.
//    On en=1, gate re-asserts only if the state is NOTE.
//  - Reset asserted mid-note: reset state on the next clk edge, regardless of en.
// CONFIGURATION
//  ARP_UPDOWN_EN defined:
//    - dir=1x selects ping-pong: run up to the highest held key, then down to the lowest.
//    - Endpoints are not repeated; a 1-bit direction register flips at each endpoint.
//    - The direction register resets to up and is cleared on IDLE entry.
//  ARP_UPDOWN_EN undefined:
//    - dir=1x behaves exactly as 00 (up).
//    - No direction register is synthesised.
// TESTING (NUM_KEYS=13, STEP_CYCLES=8, GATE_CYCLES=6)
//  1 Reset: n_rst=0 for 2 cycles with keys_held=13'h1FFF.
//    -> keycode=0, gate=0, step_pulse=0 while n_rst=0.
//  2 Up sequence: keys_held bits {1,4,9}, dir=00.
//    -> keycode 2,5,10,2 on successive 8-cycle steps.
//    -> gate high 6 cycles / low 2 cycles; one step_pulse per step.
//  3 Down + release: bits {0,3}, dir=01 -> keycode 4 then 1.
//    Clear bit 0 at counter=2 -> gate drops next cycle.
//    Next step end -> keycode 4 again.
//  4 All released mid-step -> IDLE next cycle, keycode=0, gate=0.
//    Re-press bit 5 -> keycode 6, step_pulse=1 one cycle later.
//  5 en low for 20 cycles mid-NOTE -> gate=0, keycode and counter frozen.
//    en high -> gate=1, step resumes from the frozen count.
//  6 (ARP_UPDOWN_EN) bits {0,2,4}, dir=10 -> keycode 1,3,5,3,1,3.
//    Without the macro, same stimulus -> 1,3,5,1,3,5.

Source files
------------

// File: rtl/arp_scheduler.sv
// Arpeggiator step scheduler: plays held keypad keys one at a time at a fixed tempo.
// Optional feature macro ARP_UPDOWN_EN enables ping-pong mode on dir=1x.
module arp_scheduler #(
  parameter int unsigned NUM_KEYS    = 13,
  parameter int unsigned STEP_CYCLES = 1_500_000,
  parameter int unsigned GATE_CYCLES = 1_125_000,
  parameter int unsigned CNT_W       = 21
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] keys_held,
  input  logic [1:0]          dir,
  output logic [3:0]          keycode,
  output logic                gate,
  output logic                step_pulse
);

  localparam int NK = int'(NUM_KEYS);
  localparam logic [CNT_W-1:0] StepLast = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GateLast = CNT_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StNote, StGap} state_e;

  function automatic logic [3:0] lowest_set(input logic [NUM_KEYS-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] highest_set(input logic [NUM_KEYS-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NK; i++) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Nearest set bit strictly after cur in the given direction, wrapping; cur itself is the
  // farthest candidate so a lone held key repeats.
  function automatic logic [3:0] next_wrap(input logic [NUM_KEYS-1:0] m,
                                           input logic [3:0] cur, input logic down);
    logic [3:0] r;
    int         c, d, best;
    r    = cur;
    c    = int'(cur);
    best = NK + 1;
    for (int i = 0; i < NK; i++) begin
      if (down) d = (i < c) ? (c - i) : (c + NK - i);
      else      d = (i > c) ? (i - c) : (i + NK - c);
      if (m[i] && d < best) begin
        best = d;
        r    = 4'(i);
      end
    end
    return r;
  endfunction

  // Nearest set bit strictly beyond cur without wrapping; msb of the result flags a hit.
  function automatic logic [4:0] next_lin(input logic [NUM_KEYS-1:0] m,
                                          input logic [3:0] cur, input logic down);
    logic [3:0] r;
    logic       found;
    int         c, d, best;
    r     = cur;
    found = 1'b0;
    c     = int'(cur);
    best  = NK + 1;
    for (int i = 0; i < NK; i++) begin
      d = down ? (c - i) : (i - c);
      if (m[i] && d > 0 && d < best) begin
        best  = d;
        r     = 4'(i);
        found = 1'b1;
      end
    end
    return {found, r};
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cur_idx_q, cur_idx_d;
  logic [3:0]        keycode_q, keycode_d;
  logic              gate_q, gate_d;
  logic              pulse_q, pulse_d;

  logic              any_held, cur_held, down_mode, step_end;
  logic [3:0]        start_idx, next_idx;

  assign any_held  = |keys_held;
  assign cur_held  = |(keys_held & (NUM_KEYS'(1) << cur_idx_q));
  assign down_mode = (dir == 2'b01);
  assign step_end  = (cnt_q == StepLast);
  assign start_idx = down_mode ? highest_set(keys_held) : lowest_set(keys_held);

`ifdef ARP_UPDOWN_EN
  // 0 = ascending, 1 = descending leg of the ping-pong
  logic       dir_q, dir_d, next_dir;
  logic [4:0] fwd_hit, rev_hit;

  always_comb begin
    fwd_hit  = next_lin(keys_held, cur_idx_q, dir_q);
    rev_hit  = next_lin(keys_held, cur_idx_q, !dir_q);
    next_dir = dir_q;
    if (!dir[1]) begin
      next_idx = next_wrap(keys_held, cur_idx_q, down_mode);
    end else if (fwd_hit[4]) begin
      next_idx = fwd_hit[3:0];
    end else if (rev_hit[4]) begin
      next_idx = rev_hit[3:0];
      next_dir = !dir_q;
    end else begin
      next_idx = cur_idx_q;
    end
  end
`else
  always_comb begin
    next_idx = next_wrap(keys_held, cur_idx_q, down_mode);
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_idx_d = cur_idx_q;
    keycode_d = keycode_q;
    pulse_d   = 1'b0;
`ifdef ARP_UPDOWN_EN
    dir_d     = dir_q;
`endif
    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (any_held) begin
            state_d   = StNote;
            cnt_d     = '0;
            cur_idx_d = start_idx;
            keycode_d = start_idx + 4'd1;
            pulse_d   = 1'b1;
`ifdef ARP_UPDOWN_EN
            dir_d     = 1'b0;
`endif
          end
        end
        StNote, StGap: begin
          cnt_d = step_end ? '0 : cnt_q + 1'b1;
          if (!any_held) begin
            state_d   = StIdle;
            cnt_d     = '0;
            cur_idx_d = '0;
            keycode_d = '0;
`ifdef ARP_UPDOWN_EN
            dir_d     = 1'b0;
`endif
          end else if (step_end) begin
            state_d   = StNote;
            cur_idx_d = next_idx;
            keycode_d = next_idx + 4'd1;
            pulse_d   = 1'b1;
`ifdef ARP_UPDOWN_EN
            dir_d     = next_dir;
`endif
          end else if (state_q == StNote && (cnt_q == GateLast || !cur_held)) begin
            // Releasing the sounding key only mutes; the step keeps its timing.
            state_d = StGap;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    gate_d = en && (state_d == StNote);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cur_idx_q <= '0;
      keycode_q <= '0;
      gate_q    <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef ARP_UPDOWN_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_idx_q <= cur_idx_d;
      keycode_q <= keycode_d;
      gate_q    <= gate_d;
      pulse_q   <= pulse_d;
`ifdef ARP_UPDOWN_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign keycode    = keycode_q;
  assign gate       = gate_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_arp_scheduler.sv
// Directed self-checking bench for arp_scheduler (NUM_KEYS=13, STEP_CYCLES=8, GATE_CYCLES=6).
module tb_arp_scheduler;

  logic        clk;
  logic        n_rst;
  logic        en;
  logic [12:0] keys_held;
  logic [1:0]  dir;
  logic [3:0]  keycode;
  logic        gate;
  logic        step_pulse;

  int total = 0;
  int bad   = 0;

  arp_scheduler #(
    .NUM_KEYS   (13),
    .STEP_CYCLES(8),
    .GATE_CYCLES(6),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .en        (en),
    .keys_held (keys_held),
    .dir       (dir),
    .keycode   (keycode),
    .gate      (gate),
    .step_pulse(step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_rst     = 1'b0;
    en        = 1'b1;
    keys_held = 13'h1FFF;
    dir       = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (keycode !== 4'd0 || gate !== 1'b0 || step_pulse !== 1'b0) begin
        $display("FAIL reset cyc=%0d got kc=%0d g=%b p=%b want kc=0 g=0 p=0",
                 i, keycode, gate, step_pulse);
        bad++;
      end
    end
    n_rst     = 1'b1;
    keys_held = 13'h0;
    tick();
    total++;
    if (keycode !== 4'd0 || gate !== 1'b0) begin
      $display("FAIL reset_idle got kc=%0d g=%b want kc=0 g=0", keycode, gate);
      bad++;
    end
  endtask

  task automatic go_idle(input string name);
    keys_held = 13'h0;
    tick();
    total++;
    if (keycode !== 4'd0 || gate !== 1'b0 || step_pulse !== 1'b0) begin
      $display("FAIL %s_idle got kc=%0d g=%b p=%b want kc=0 g=0 p=0",
               name, keycode, gate, step_pulse);
      bad++;
    end
  endtask

  task automatic test_up;
    logic [3:0] seq [4];
    seq       = '{4'd2, 4'd5, 4'd10, 4'd2};
    dir       = 2'b00;
    keys_held = 13'h212;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        total++;
        if (keycode !== seq[s] || gate !== (c < 6) || step_pulse !== (c == 0)) begin
          $display("FAIL up s=%0d c=%0d got kc=%0d g=%b p=%b want kc=%0d g=%b p=%b",
                   s, c, keycode, gate, step_pulse, seq[s], c < 6, c == 0);
          bad++;
        end
      end
    end
    go_idle("up");
  endtask

  task automatic test_down_release;
    dir       = 2'b01;
    keys_held = 13'h009;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin
        total++;
        if (keycode !== 4'd4 || step_pulse !== 1'b1) begin
          $display("FAIL down_first got kc=%0d p=%b want kc=4 p=1", keycode, step_pulse);
          bad++;
        end
      end
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (keycode !== 4'd1 || gate !== (c < 3)) begin
        $display("FAIL down_release c=%0d got kc=%0d g=%b want kc=1 g=%b",
                 c, keycode, gate, c < 3);
        bad++;
      end
      if (c == 2) keys_held = 13'h008;
    end
    tick();
    total++;
    if (keycode !== 4'd4 || gate !== 1'b1 || step_pulse !== 1'b1) begin
      $display("FAIL down_wrap got kc=%0d g=%b p=%b want kc=4 g=1 p=1",
               keycode, gate, step_pulse);
      bad++;
    end
  endtask

  task automatic test_release_all;
    tick();
    tick();
    keys_held = 13'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (keycode !== 4'd0 || gate !== 1'b0 || step_pulse !== 1'b0) begin
        $display("FAIL release_all i=%0d got kc=%0d g=%b p=%b want kc=0 g=0 p=0",
                 i, keycode, gate, step_pulse);
        bad++;
      end
    end
    dir       = 2'b00;
    keys_held = 13'h020;
    tick();
    total++;
    if (keycode !== 4'd6 || gate !== 1'b1 || step_pulse !== 1'b1) begin
      $display("FAIL repress got kc=%0d g=%b p=%b want kc=6 g=1 p=1",
               keycode, gate, step_pulse);
      bad++;
    end
    tick();
    total++;
    if (step_pulse !== 1'b0 || gate !== 1'b1) begin
      $display("FAIL repress_after got p=%b g=%b want p=0 g=1", step_pulse, gate);
      bad++;
    end
  endtask

  // Entered with counter at 1 in NOTE holding keycode 6.
  task automatic test_en_freeze;
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (keycode !== 4'd6 || gate !== 1'b0 || step_pulse !== 1'b0) begin
        $display("FAIL freeze i=%0d got kc=%0d g=%b p=%b want kc=6 g=0 p=0",
                 i, keycode, gate, step_pulse);
        bad++;
      end
    end
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      total++;
      if (keycode !== 4'd6 || gate !== (k < 4 || k == 6) || step_pulse !== (k == 6)) begin
        $display("FAIL resume k=%0d got kc=%0d g=%b p=%b want kc=6 g=%b p=%b",
                 k, keycode, gate, step_pulse, k < 4 || k == 6, k == 6);
        bad++;
      end
    end
    go_idle("freeze");
  endtask

  task automatic test_pingpong;
    logic [3:0] seq [6];
`ifdef ARP_UPDOWN_EN
    seq = '{4'd1, 4'd3, 4'd5, 4'd3, 4'd1, 4'd3};
`else
    seq = '{4'd1, 4'd3, 4'd5, 4'd1, 4'd3, 4'd5};
`endif
    dir       = 2'b10;
    keys_held = 13'h015;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        if (c == 0 || c == 7) begin
          total++;
          if (keycode !== seq[s] || step_pulse !== (c == 0)) begin
            $display("FAIL pingpong s=%0d c=%0d got kc=%0d p=%b want kc=%0d p=%b",
                     s, c, keycode, step_pulse, seq[s], c == 0);
            bad++;
          end
        end
      end
    end
    go_idle("pingpong");
  endtask

  task automatic test_reset_mid;
    dir       = 2'b00;
    keys_held = 13'h020;
    tick();
    tick();
    en    = 1'b0;
    n_rst = 1'b0;
    tick();
    total++;
    if (keycode !== 4'd0 || gate !== 1'b0 || step_pulse !== 1'b0) begin
      $display("FAIL reset_mid got kc=%0d g=%b p=%b want kc=0 g=0 p=0",
               keycode, gate, step_pulse);
      bad++;
    end
    n_rst = 1'b1;
    en    = 1'b1;
    tick();
    total++;
    if (keycode !== 4'd6 || step_pulse !== 1'b1) begin
      $display("FAIL reset_restart got kc=%0d p=%b want kc=6 p=1", keycode, step_pulse);
      bad++;
    end
    go_idle("reset_mid");
  endtask

  initial begin
    test_reset();
    test_up();
    test_down_release();
    test_release_all();
    test_en_freeze();
    test_pingpong();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
